// File: rtl/cpu_mem_arbiter_pkg.sv
// rtl/cpu_mem_arbiter_pkg.sv - shared types and constants for the CPU memory arbiter
package cpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] ARB_M_IBUS = 2'd0;
  localparam logic [1:0] ARB_M_DBUS = 2'd1;

  localparam int ARB_ADDR_W = 30;
  localparam int ARB_DATA_W = 32;

endpackage

// File: rtl/cpu_mem_arbiter_grant_sel.sv
// rtl/cpu_mem_arbiter_grant_sel.sv - next-grant selection; ARB_ROUND_ROBIN_EN picks round-robin over fixed DBus priority
module arb_grant_sel
  import cpu_mem_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [1:0] last_grant_i,
`endif
  input  logic       ireq_i,
  input  logic       dreq_i,
  output logic       gnt_i_o,
  output logic       gnt_d_o
);

  always_comb begin
    gnt_i_o = 1'b0;
    gnt_d_o = 1'b0;
    if (ireq_i && dreq_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      // Hand the slave to whichever master did not complete last.
      if (last_grant_i == ARB_M_DBUS) gnt_i_o = 1'b1;
      else                            gnt_d_o = 1'b1;
`else
      gnt_d_o = 1'b1;
`endif
    end else begin
      gnt_i_o = ireq_i;
      gnt_d_o = dreq_i;
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - IBus/DBus to single memory port arbiter with locked grant FSM
// Optional ARB_ROUND_ROBIN_EN enables round-robin arbitration and the last-grant register.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic [ADDR_W-1:0]   i_IBus_Address,
  input  logic                i_IBus_Read,
  output logic [DATA_W-1:0]   o_IBus_ReadData,
  output logic                o_IBus_WaitReq,
  input  logic [ADDR_W-1:0]   i_DBus_Address,
  input  logic [DATA_W/8-1:0] i_DBus_ByteEn,
  input  logic                i_DBus_Read,
  input  logic                i_DBus_Write,
  input  logic [DATA_W-1:0]   i_DBus_WriteData,
  output logic [DATA_W-1:0]   o_DBus_ReadData,
  output logic                o_DBus_WaitReq,
  output logic [ADDR_W-1:0]   o_Mem_Address,
  output logic [DATA_W/8-1:0] o_Mem_ByteEn,
  output logic                o_Mem_Read,
  output logic                o_Mem_Write,
  output logic [DATA_W-1:0]   o_Mem_WriteData,
  input  logic [DATA_W-1:0]   i_Mem_ReadData,
  input  logic                i_Mem_WaitReq
);

  arb_state_e state_q, state_d;
  logic       ireq, dreq, gnt_i, gnt_d, done_i, done_d;

  assign ireq = i_IBus_Read;
  assign dreq = i_DBus_Read | i_DBus_Write;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_q, last_d;
`endif

  arb_grant_sel u_grant_sel (
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant_i (last_q),
`endif
    .ireq_i       (ireq),
    .dreq_i       (dreq),
    .gnt_i_o      (gnt_i),
    .gnt_d_o      (gnt_d)
  );

  assign done_i = (state_q == ARB_GNT_I) && ireq && !i_Mem_WaitReq;
  assign done_d = (state_q == ARB_GNT_D) && dreq && !i_Mem_WaitReq;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_d)      state_d = ARB_GNT_D;
        else if (gnt_i) state_d = ARB_GNT_I;
      end
      // A dropped request is treated like completion so the slave is released.
      ARB_GNT_I: if (!ireq || !i_Mem_WaitReq) state_d = ARB_IDLE;
      ARB_GNT_D: if (!dreq || !i_Mem_WaitReq) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d = last_q;
    if (done_i) last_d = ARB_M_IBUS;
    if (done_d) last_d = ARB_M_DBUS;
  end
`endif

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= ARB_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= ARB_M_IBUS;
`endif
    end else begin
      state_q <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  always_comb begin
    o_Mem_Address   = '0;
    o_Mem_ByteEn    = '0;
    o_Mem_Read      = 1'b0;
    o_Mem_Write     = 1'b0;
    o_Mem_WriteData = '0;
    case (state_q)
      ARB_GNT_I: begin
        o_Mem_Address = i_IBus_Address;
        o_Mem_ByteEn  = '1;
        o_Mem_Read    = ireq;
      end
      ARB_GNT_D: begin
        o_Mem_Address   = i_DBus_Address;
        o_Mem_ByteEn    = i_DBus_ByteEn;
        o_Mem_WriteData = i_DBus_WriteData;
        o_Mem_Write     = i_DBus_Write;
        o_Mem_Read      = i_DBus_Read & ~i_DBus_Write;
      end
      default: ;
    endcase
  end

  assign o_IBus_WaitReq  = ~done_i;
  assign o_DBus_WaitReq  = ~done_d;
  assign o_IBus_ReadData = i_Mem_ReadData;
  assign o_DBus_ReadData = i_Mem_ReadData;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - scoreboard bench for cpu_mem_arbiter; ARB_ROUND_ROBIN_EN selects expected grant order
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] ib_addr = '0;
  logic        ib_rd = 1'b0;
  logic [31:0] ib_rdata;
  logic        ib_wait;
  logic [29:0] db_addr = '0;
  logic [3:0]  db_be = '0;
  logic        db_rd = 1'b0;
  logic        db_wr = 1'b0;
  logic [31:0] db_wdata = '0;
  logic [31:0] db_rdata;
  logic        db_wait;
  logic [29:0] m_addr;
  logic [3:0]  m_be;
  logic        m_rd, m_wr;
  logic [31:0] m_wdata, m_rdata;
  logic        m_wait;

  always #5 clk = ~clk;

  cpu_mem_arbiter dut (
    .i_Clk            (clk),
    .i_Reset          (rst),
    .i_IBus_Address   (ib_addr),
    .i_IBus_Read      (ib_rd),
    .o_IBus_ReadData  (ib_rdata),
    .o_IBus_WaitReq   (ib_wait),
    .i_DBus_Address   (db_addr),
    .i_DBus_ByteEn    (db_be),
    .i_DBus_Read      (db_rd),
    .i_DBus_Write     (db_wr),
    .i_DBus_WriteData (db_wdata),
    .o_DBus_ReadData  (db_rdata),
    .o_DBus_WaitReq   (db_wait),
    .o_Mem_Address    (m_addr),
    .o_Mem_ByteEn     (m_be),
    .o_Mem_Read       (m_rd),
    .o_Mem_Write      (m_wr),
    .o_Mem_WriteData  (m_wdata),
    .i_Mem_ReadData   (m_rdata),
    .i_Mem_WaitReq    (m_wait)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Slave model: fixed wait count per transfer, address-derived read data
  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (a == 30'h100) return 32'h0000_0013;
    return {a[15:0], 16'hC0DE} ^ 32'h5A00_0000;
  endfunction

  int slv_wait = 0;
  int wcnt = 0;
  assign m_wait  = (m_rd | m_wr) && (wcnt < slv_wait);
  assign m_rdata = mem_rd(m_addr);

  always @(posedge clk or posedge rst) begin
    if (rst)                wcnt <= 0;
    else if (m_rd | m_wr)   wcnt <= m_wait ? wcnt + 1 : 0;
    else                    wcnt <= 0;
  end

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
  } dcmd_t;

  typedef struct {
    logic        is_d;
    logic [29:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic [29:0] iq[$];
  dcmd_t       dq[$];
  exp_t        sb[$];
  logic        i_done_s = 1'b0;
  logic        d_done_s = 1'b0;

  task automatic q_i(input logic [29:0] a);
    iq.push_back(a);
  endtask

  task automatic q_d(input logic [29:0] a, input logic [3:0] be, input logic rd,
                     input logic wr, input logic [31:0] wd);
    dcmd_t c;
    c.addr = a; c.be = be; c.rd = rd; c.wr = wr; c.wdata = wd;
    dq.push_back(c);
  endtask

  task automatic e_i(input logic [29:0] a);
    exp_t e;
    e.is_d = 1'b0; e.addr = a; e.be = 4'hF; e.wr = 1'b0; e.wdata = '0; e.rdata = mem_rd(a);
    sb.push_back(e);
  endtask

  task automatic e_d(input logic [29:0] a, input logic [3:0] be, input logic wr,
                     input logic [31:0] wd);
    exp_t e;
    e.is_d = 1'b1; e.addr = a; e.be = be; e.wr = wr; e.wdata = wd; e.rdata = mem_rd(a);
    sb.push_back(e);
  endtask

  // Master drivers: hold the head command until its completion cycle is seen
  initial forever begin
    @(posedge clk); #1;
    if (i_done_s && iq.size() > 0) void'(iq.pop_front());
    if (iq.size() > 0) begin ib_rd = 1'b1; ib_addr = iq[0]; end
    else                ib_rd = 1'b0;
  end

  initial forever begin
    @(posedge clk); #1;
    if (d_done_s && dq.size() > 0) void'(dq.pop_front());
    if (dq.size() > 0) begin
      db_addr = dq[0].addr; db_be = dq[0].be; db_rd = dq[0].rd;
      db_wr = dq[0].wr; db_wdata = dq[0].wdata;
    end else begin
      db_rd = 1'b0; db_wr = 1'b0;
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    i_done_s = !ib_wait;
    d_done_s = !db_wait;
    if (!ib_wait && !db_wait) check("both_done", 1, 0);
    if (!ib_wait) begin
      if (sb.size() == 0) check("i_unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("cmp_master_i", 0, {63'd0, e.is_d});
        check("cmp_addr_i", {34'd0, m_addr}, {34'd0, e.addr});
        check("cmp_rd_i", {63'd0, m_rd}, 1);
        check("cmp_be_i", {60'd0, m_be}, 64'hF);
        check("cmp_rdata_i", {32'd0, ib_rdata}, {32'd0, e.rdata});
      end
    end
    if (!db_wait) begin
      if (sb.size() == 0) check("d_unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("cmp_master_d", 1, {63'd0, e.is_d});
        check("cmp_addr_d", {34'd0, m_addr}, {34'd0, e.addr});
        check("cmp_wr_d", {63'd0, m_wr}, {63'd0, e.wr});
        check("cmp_rd_d", {63'd0, m_rd}, {63'd0, !e.wr});
        check("cmp_be_d", {60'd0, m_be}, {60'd0, e.be});
        if (e.wr) check("cmp_wdata_d", {32'd0, m_wdata}, {32'd0, e.wdata});
        else      check("cmp_rdata_d", {32'd0, db_rdata}, {32'd0, e.rdata});
      end
    end
  end

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((sb.size() > 0 || iq.size() > 0 || dq.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check(tag, 1, 0);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    check("rst_mem_rd", {63'd0, m_rd}, 0);
    check("rst_mem_wr", {63'd0, m_wr}, 0);
    check("rst_mem_addr", {34'd0, m_addr}, 0);
    check("rst_mem_be", {60'd0, m_be}, 0);
    check("rst_mem_wdata", {32'd0, m_wdata}, 0);
    check("rst_ib_wait", {63'd0, ib_wait}, 1);
    check("rst_db_wait", {63'd0, db_wait}, 1);
    rst = 1'b0;
    @(negedge clk);

    // IBus read, zero-wait slave
    slv_wait = 0;
    q_i(30'h100); e_i(30'h100);
    @(negedge clk);
    check("t1_c0_rd", {63'd0, m_rd}, 0);
    @(negedge clk);
    check("t1_c1_rd", {63'd0, m_rd}, 1);
    check("t1_c1_addr", {34'd0, m_addr}, 64'h100);
    check("t1_c1_be", {60'd0, m_be}, 64'hF);
    check("t1_c1_iwait", {63'd0, ib_wait}, 0);
    check("t1_c1_rdata", {32'd0, ib_rdata}, 64'h13);
    @(negedge clk);
    check("t1_c2_rd", {63'd0, m_rd}, 0);
    check("t1_c2_iwait", {63'd0, ib_wait}, 1);
    wait_drain("t1_timeout", 20);

    // DBus write with three slave wait cycles
    slv_wait = 3;
    q_d(30'h40, 4'h3, 1'b0, 1'b1, 32'hDEAD_BEEF); e_d(30'h40, 4'h3, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t2_c0_wr", {63'd0, m_wr}, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("t2_wr", {63'd0, m_wr}, 1);
      check("t2_addr", {34'd0, m_addr}, 64'h40);
      check("t2_be", {60'd0, m_be}, 64'h3);
      check("t2_wdata", {32'd0, m_wdata}, 64'hDEAD_BEEF);
      check("t2_dwait", {63'd0, db_wait}, (k == 4) ? 64'd0 : 64'd1);
      check("t2_iwait", {63'd0, ib_wait}, 1);
    end
    @(negedge clk);
    check("t2_after_wr", {63'd0, m_wr}, 0);
    wait_drain("t2_timeout", 20);

    // Both masters requesting continuously
    slv_wait = 0;
    for (int k = 0; k < 4; k++) q_d(30'h300 + k, 4'hF, 1'b1, 1'b0, '0);
    for (int k = 0; k < 2; k++) q_i(30'h500 + k);
`ifdef ARB_ROUND_ROBIN_EN
    e_d(30'h300, 4'hF, 1'b0, '0); e_i(30'h500);
    e_d(30'h301, 4'hF, 1'b0, '0); e_i(30'h501);
    e_d(30'h302, 4'hF, 1'b0, '0); e_d(30'h303, 4'hF, 1'b0, '0);
`else
    for (int k = 0; k < 4; k++) e_d(30'h300 + k, 4'hF, 1'b0, '0);
    e_i(30'h500); e_i(30'h501);
`endif
    wait_drain("t3_timeout", 200);

    // Read and write together: write wins
    q_d(30'h44, 4'hC, 1'b1, 1'b1, 32'h1234_5678); e_d(30'h44, 4'hC, 1'b1, 32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    check("t4_wr", {63'd0, m_wr}, 1);
    check("t4_rd", {63'd0, m_rd}, 0);
    wait_drain("t4_timeout", 20);

    // Reset during the second wait cycle of a DBus read
    slv_wait = 3;
    q_d(30'h80, 4'hF, 1'b1, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t5_pre_rd", {63'd0, m_rd}, 1);
    rst = 1'b1;
    dq.delete();
    #1;
    check("t5_rst_rd", {63'd0, m_rd}, 0);
    check("t5_rst_iwait", {63'd0, ib_wait}, 1);
    check("t5_rst_dwait", {63'd0, db_wait}, 1);
    @(negedge clk);
    rst = 1'b0;
    slv_wait = 1;
    q_i(30'h200); e_i(30'h200);
    wait_drain("t5_timeout", 30);
    check("sb_empty", {32'd0, sb.size()}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Two-master to one-slave memory arbiter that sits directly downstream of the CPU core. It merges the CPU instruction bus (read-only) and data bus (read/write) onto a single word-addressed memory port with waitrequest handshaking. A registered grant FSM locks the slave to one master until its transfer completes.

## Interface
- ADDR_W, 30, word address width (byte address bits [31:2])
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- i_Clk  in  1  system clock, rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_IBus_Address  in  ADDR_W  instruction fetch word address
- i_IBus_Read  in  1  instruction read request
- o_IBus_ReadData  out  DATA_W  instruction read data
- o_IBus_WaitReq  out  1  stall to instruction master
- i_DBus_Address  in  ADDR_W  data word address
- i_DBus_ByteEn  in  DATA_W/8  data byte enables
- i_DBus_Read  in  1  data read request
- i_DBus_Write  in  1  data write request
- i_DBus_WriteData  in  DATA_W  store data
- o_DBus_ReadData  out  DATA_W  load data
- o_DBus_WaitReq  out  1  stall to data master
- o_Mem_Address  out  ADDR_W  slave address
- o_Mem_ByteEn  out  DATA_W/8  slave byte enables
- o_Mem_Read  out  1  slave read strobe
- o_Mem_Write  out  1  slave write strobe
- o_Mem_WriteData  out  DATA_W  slave write data
- i_Mem_ReadData  in  DATA_W  slave read data, valid in the cycle i_Mem_WaitReq is low during a read
- i_Mem_WaitReq  in  1  slave stall

## Operation
- FSM states: IDLE, GNT_I, GNT_D. Reset enters IDLE.
- IDLE:
  - No slave strobes.
  - Sample requests: ireq = i_IBus_Read; dreq = i_DBus_Read | i_DBus_Write.
  - Only ireq -> GNT_I. Only dreq -> GNT_D.
  - Both -> resolved per Configuration.
- GNT_I:
  - o_Mem_Address = i_IBus_Address, o_Mem_ByteEn = all ones, o_Mem_Read = 1, o_Mem_Write = 0.
- GNT_D:
  - All i_DBus_* fields forwarded to o_Mem_*.
- Completion: in a grant state, the cycle with i_Mem_WaitReq = 0.
  - The granted master's WaitReq drops to 0 for that one cycle.
  - Read data is routed combinationally (o_IBus_ReadData / o_DBus_ReadData = i_Mem_ReadData).
  - FSM returns to IDLE.
- Master WaitReq is 1 in every cycle except its own completion cycle.
- The non-granted master's ReadData is don't-care; drive i_Mem_ReadData to both.
- Masters hold command fields stable while WaitReq = 1. The arbiter does not re-register them.
- i_DBus_Read and i_DBus_Write together: the write takes effect and Read is suppressed toward the slave.
- Request dropped by a master mid-grant (protocol violation): strobes deassert, and the FSM returns to IDLE on the next cycle.
- A 2-bit last-grant register records which master completed most recently; it is used only by round-robin.

## Timing
- Reset values:
  - FSM = IDLE, last-grant = IBUS.
  - o_Mem_Read = o_Mem_Write = 0; o_Mem_Address, o_Mem_ByteEn, o_Mem_WriteData = 0.
  - o_IBus_WaitReq = o_DBus_WaitReq = 1.
- Asserting reset mid-transfer aborts immediately. Strobes go low asynchronously and no completion is signalled.
- Minimum latency from request to completion is 2 cycles: IDLE sample cycle plus one grant cycle with i_Mem_WaitReq = 0.
- Each slave wait cycle adds one cycle.
- One IDLE bubble separates back-to-back grants, so peak throughput is 1 transfer per 2 cycles.
- Slave strobes are Moore outputs of the FSM state. Master WaitReq and ReadData are combinational from i_Mem_WaitReq / i_Mem_ReadData.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - Simultaneous requests in IDLE grant the master opposite the last-grant register.
  - Neither master can be starved beyond one transfer.
- ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: DBus always wins simultaneous requests.
  - The last-grant register is removed.

## Structure
- Shared package holds:
  - State enum: ARB_IDLE, ARB_GNT_I, ARB_GNT_D.
  - Master ID constants: ARB_M_IBUS = 0, ARB_M_DBUS = 1.
  - Default ADDR_W / DATA_W.
- One sub-module, arb_grant_sel: combinational next-grant selection from ireq, dreq and last-grant. It contains the ARB_ROUND_ROBIN_EN switch.
- Datapath muxes and the FSM stay in cpu_mem_arbiter.

## Test plan
- IBus read only at address 0x0000100, slave zero-wait returning 0x00000013 -> o_Mem_Read high in cycle 1 with address 0x0000100 and ByteEn 0xF; o_IBus_WaitReq = 0 and ReadData = 0x00000013 in cycle 1; FSM back in IDLE in cycle 2.
- DBus write at address 0x0000040, ByteEn 0x3, data 0xDEADBEEF, slave waits 3 cycles -> o_Mem_Write held 4 cycles with stable fields; o_DBus_WaitReq drops only in the 4th cycle; o_IBus_WaitReq stays 1 throughout.
- Both masters request continuously with zero-wait slave:
  - Round-robin build: grants alternate D, I, D, I (reset last-grant = IBUS).
  - Fixed-priority build: DBus granted every transfer and IBus never completes.
- i_DBus_Read and i_DBus_Write both asserted -> o_Mem_Write = 1 and o_Mem_Read = 0.
- i_Reset pulsed during the 2nd wait cycle of a DBus read -> o_Mem_Read = 0 immediately; both WaitReq = 1; no completion; a fresh IBus request afterwards completes normally.
